// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader and
// the fetch/halt-detect path, so both agree on the end-of-program marker.
package program_loader_pkg;

  localparam int          PL_ADDR_W    = 8;
  localparam logic [31:0] PL_HALT_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus instruction-memory write port seen by the loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PL_ADDR_W
);

  // Byte stream: a byte moves on a rising edge where in_valid && in_ready.
  // The source keeps in_data stable and in_valid high until that edge;
  // in_valid without in_ready consumes nothing.
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction addresses; releases the CPU once the halt word lands.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          ADDR_W    = PL_ADDR_W,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = PL_HALT_WORD
) (
  input  logic          clk,
  input  logic          rst,
  program_loader_if.slave bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output loader_state_e state_dbg
);

  loader_state_e     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              ready;
  logic              xfer;

  assign ready = (state_q == ST_LOAD) && !rst;
  assign xfer  = ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    unique case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          word_d = {word_q[23:0], bus.in_data};
          cnt_d  = cnt_q + 2'd1;
          // Latch the write port on the 4th byte so it holds after WRITE.
          if (cnt_q == 2'd3) begin
            state_d = ST_WRITE;
            maddr_d = addr_q;
            mdata_d = word_d;
          end
        end
      end
      ST_WRITE: begin
        if (word_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_ERR;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mdata_q;
  assign done          = (state_q == ST_DONE);
  assign err           = (state_q == ST_ERR);
  assign cpu_rst       = (state_q != ST_DONE);
  assign state_dbg     = state_q;

endmodule
